// File: rtl/commit_sequencer_if.sv
// Commit-to-report bus: two-lane retire input, drain stall, and the single-lane report output.
// The sequencer takes the slave view; the commit stage and harness take the master view.
interface commit_sequencer_if;
  logic        in_valid0;
  logic [63:0] in_pc0;
  logic [31:0] in_inst0;
  logic        in_mmio0;
  logic [11:0] in_rcsr0;
  logic        in_valid1;
  logic [63:0] in_pc1;
  logic [31:0] in_inst1;
  logic        in_mmio1;
  logic [11:0] in_rcsr1;
  logic        in_ready;
  logic        drain_stall;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_mmio;
  logic [11:0] out_rcsr;

  modport master (
    output in_valid0, in_pc0, in_inst0, in_mmio0, in_rcsr0,
    output in_valid1, in_pc1, in_inst1, in_mmio1, in_rcsr1,
    output drain_stall,
    input  in_ready,
    input  out_valid, out_pc, out_inst, out_mmio, out_rcsr
  );

  modport slave (
    input  in_valid0, in_pc0, in_inst0, in_mmio0, in_rcsr0,
    input  in_valid1, in_pc1, in_inst1, in_mmio1, in_rcsr1,
    input  drain_stall,
    output in_ready,
    output out_valid, out_pc, out_inst, out_mmio, out_rcsr
  );
endinterface

// File: rtl/commit_sequencer.sv
// Serializes up to two in-order retired records per cycle into a one-record-per-cycle report
// stream through a small FIFO, with backpressure, drain stall and a reported-instruction counter.
module commit_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  commit_sequencer_if.slave     bus,
  output logic [CNT_W-1:0]      commit_cnt,
  output logic                  proto_err
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mmio;
    logic [11:0] rcsr;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [CNT_W-1:0]  commit_cnt_q, commit_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic              in_ready;
  logic              deq;
  logic              wr0, wr1;
  logic [1:0]        n_in;
  logic [PtrW-1:0]   wptr1;
  entry_t            lane0, lane1, head;

  assign lane0 = '{pc: bus.in_pc0, inst: bus.in_inst0, mmio: bus.in_mmio0, rcsr: bus.in_rcsr0};
  assign lane1 = '{pc: bus.in_pc1, inst: bus.in_inst1, mmio: bus.in_mmio1, rcsr: bus.in_rcsr1};
  assign head  = mem_q[rptr_q];

  always_comb begin
    // Two free slots guarantee both lanes fit regardless of this cycle's dequeue.
    in_ready     = (count_q <= CountW'(DEPTH - 2));
    wr0          = in_ready & bus.in_valid0;
    wr1          = in_ready & bus.in_valid1;
    n_in         = {1'b0, wr0} + {1'b0, wr1};
    wptr1        = wptr_q + PtrW'(wr0);
    deq          = (count_q != '0) && !bus.drain_stall;
    wptr_d       = wptr_q + PtrW'(n_in);
    rptr_d       = rptr_q + PtrW'(deq);
    count_d      = count_q + CountW'(n_in) - CountW'(deq);
    commit_cnt_d = commit_cnt_q + CNT_W'(deq);
    proto_err_d  = proto_err_q | ((bus.in_valid0 | bus.in_valid1) & ~in_ready);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      commit_cnt_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      commit_cnt_q <= commit_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Payload storage needs no reset: it is only visible through out_* while count is non-zero.
  always_ff @(posedge clock) begin
    if (wr0) mem_q[wptr_q] <= lane0;
    if (wr1) mem_q[wptr1]  <= lane1;
  end

  // Idle cycles present an all-zero record to the report hook.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = deq;
    bus.out_pc    = deq ? head.pc   : '0;
    bus.out_inst  = deq ? head.inst : '0;
    bus.out_mmio  = deq ? head.mmio : 1'b0;
    bus.out_rcsr  = deq ? head.rcsr : '0;
    commit_cnt    = commit_cnt_q;
    proto_err     = proto_err_q;
  end

endmodule
